// File: rtl/pong_gfx_pkg.sv
`default_nettype none
// ============================================================================
// pong_gfx_pkg - object geometry, colours, screen limits and scheduler types
// Rev 1.0
// ============================================================================
package pong_gfx_pkg;

    localparam int PADDLE_W = 10;
    localparam int PADDLE_H = 48;
    localparam int BALL_W   = 4;
    localparam int BALL_H   = 4;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam int XW     = 9;
    localparam int YW     = 8;
    localparam int CW     = 3;
    localparam int SCAN_W = 6;

    localparam logic [CW-1:0] BG_COLOUR   = 3'b000;
    localparam logic [CW-1:0] P1_COLOUR   = 3'b111;
    localparam logic [CW-1:0] P2_COLOUR   = 3'b111;
    localparam logic [CW-1:0] BALL_COLOUR = 3'b111;

    typedef enum logic [1:0] {
        OBJ_P1   = 2'd0,
        OBJ_P2   = 2'd1,
        OBJ_BALL = 2'd2
    } obj_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DRAW   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } obj_pos_t;

    // Fixed visiting order P1 -> P2 -> BALL; BALL wraps back to P1.
    function automatic obj_idx_t next_obj(input obj_idx_t o);
        case (o)
            OBJ_P1:  return OBJ_P2;
            OBJ_P2:  return OBJ_BALL;
            default: return OBJ_P1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// pong_frame_scheduler_if - single-pixel write port towards the VGA adapter
// Rev 1.0
// ============================================================================
interface pong_frame_scheduler_if;

    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, output y, output colour, output plot);
    modport slave  (input  x, input  y, input  colour, input  plot);

endinterface
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// ============================================================================
// rect_scanner - raster xc/yc counter over a w x h rectangle, loadable to 0,0
// Rev 1.0
// ============================================================================
module rect_scanner
    import pong_gfx_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [SCAN_W-1:0] w,
    input  logic [SCAN_W-1:0] h,
    input  logic              start,
    input  logic              advance,
    output logic [SCAN_W-1:0] xc,
    output logic [SCAN_W-1:0] yc,
    output logic              last
);

    logic [SCAN_W-1:0] xc_q, xc_d;
    logic [SCAN_W-1:0] yc_q, yc_d;
    logic              row_end;
    logic              col_end;

    assign row_end = (xc_q == w - 6'd1);
    assign col_end = (yc_q == h - 6'd1);
    assign last    = row_end && col_end;
    assign xc      = xc_q;
    assign yc      = yc_q;

    // Wrapping to 0,0 after the last pixel lets the next object start at once.
    always_comb begin
        xc_d = xc_q;
        yc_d = yc_q;
        if (start) begin
            xc_d = '0;
            yc_d = '0;
        end else if (advance) begin
            if (row_end) begin
                xc_d = '0;
                yc_d = col_end ? '0 : yc_q + 6'd1;
            end else begin
                xc_d = xc_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xc_q <= '0;
            yc_q <= '0;
        end else begin
            xc_q <= xc_d;
            yc_q <= yc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_frame_scheduler.sv
`default_nettype none
// ============================================================================
// pong_frame_scheduler - per-frame erase/update/sample/draw sequencer sharing
// one VGA pixel-write port between paddle 1, paddle 2 and the ball.  Rev 1.0
// ============================================================================
module pong_frame_scheduler
    import pong_gfx_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          frame_tick,
    input  logic [XW-1:0]                 p1_x,
    input  logic [YW-1:0]                 p1_y,
    input  logic [XW-1:0]                 p2_x,
    input  logic [YW-1:0]                 p2_y,
    input  logic [XW-1:0]                 ball_x,
    input  logic [YW-1:0]                 ball_y,
    pong_frame_scheduler_if.master        vga,
    output logic                          update,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic [XW:0] X_LIMIT = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] Y_LIMIT = (YW+1)'(SCREEN_H);

    sched_state_t       state_q, state_d;
    obj_idx_t           obj_q, obj_d;
    logic               drawn_valid_q, drawn_valid_d;
    logic               overrun_q, overrun_d;
    obj_pos_t [2:0]     shadow_q, shadow_d;

    obj_pos_t           cur_pos;
    logic [SCAN_W-1:0]  cur_w;
    logic [SCAN_W-1:0]  cur_h;
    logic [CW-1:0]      cur_colour;
    logic [SCAN_W-1:0]  xc;
    logic [SCAN_W-1:0]  yc;
    logic               scan_last;
    logic               scanning;
    logic [XW:0]        x_wide;
    logic [YW:0]        y_wide;

    assign scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);

    rect_scanner u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .w       (cur_w),
        .h       (cur_h),
        .start   (!scanning),
        .advance (scanning),
        .xc      (xc),
        .yc      (yc),
        .last    (scan_last)
    );

    always_comb begin
        cur_pos    = shadow_q[0];
        cur_w      = SCAN_W'(PADDLE_W);
        cur_h      = SCAN_W'(PADDLE_H);
        cur_colour = P1_COLOUR;
        case (obj_q)
            OBJ_P2: begin
                cur_pos    = shadow_q[1];
                cur_colour = P2_COLOUR;
            end
            OBJ_BALL: begin
                cur_pos    = shadow_q[2];
                cur_w      = SCAN_W'(BALL_W);
                cur_h      = SCAN_W'(BALL_H);
                cur_colour = BALL_COLOUR;
            end
            default: ;
        endcase
    end

    // Sums are kept one bit wider so off-screen pixels are recognised before truncation.
    assign x_wide     = {1'b0, cur_pos.x} + {{(XW+1-SCAN_W){1'b0}}, xc};
    assign y_wide     = {1'b0, cur_pos.y} + {{(YW+1-SCAN_W){1'b0}}, yc};
    assign vga.x      = x_wide[XW-1:0];
    assign vga.y      = y_wide[YW-1:0];
    assign vga.plot   = scanning && (x_wide < X_LIMIT) && (y_wide < Y_LIMIT);
    assign vga.colour = (state_q == ST_DRAW) ? cur_colour : BG_COLOUR;

    assign update  = (state_q == ST_UPDATE);
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

    always_comb begin
        state_d       = state_q;
        obj_d         = obj_q;
        drawn_valid_d = drawn_valid_q;
        shadow_d      = shadow_q;
        overrun_d     = overrun_q | (frame_tick && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                obj_d = OBJ_P1;
                if (frame_tick) begin
                    state_d = drawn_valid_q ? ST_ERASE : ST_UPDATE;
                end
            end
            ST_ERASE: begin
                if (scan_last) begin
                    obj_d = next_obj(obj_q);
                    if (obj_q == OBJ_BALL) begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                shadow_d[0]   = {p1_x, p1_y};
                shadow_d[1]   = {p2_x, p2_y};
                shadow_d[2]   = {ball_x, ball_y};
                drawn_valid_d = 1'b1;
                state_d       = ST_DRAW;
            end
            ST_DRAW: begin
                if (scan_last) begin
                    obj_d = next_obj(obj_q);
                    if (obj_q == OBJ_BALL) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                obj_d   = OBJ_P1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            obj_q         <= OBJ_P1;
            drawn_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            shadow_q      <= '0;
        end else begin
            state_q       <= state_d;
            obj_q         <= obj_d;
            drawn_valid_q <= drawn_valid_d;
            overrun_q     <= overrun_d;
            shadow_q      <= shadow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pong_frame_scheduler - randomized frame streams against a raster model
// Rev 1.0
// ============================================================================
module tb_pong_frame_scheduler;

    // Record layout: {plot, x[8:0], y[7:0], colour[2:0], update, busy}
    typedef logic [22:0] rec_t;
    localparam rec_t MASK_ALL  = 23'h7FFFFF;
    localparam rec_t MASK_NOXY = 23'h40001F;

    typedef struct packed {
        logic [8:0] x0, x1, x2;
        logic [7:0] y0, y1, y2;
    } snap_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic [8:0] dx [3];
    logic [7:0] dy [3];
    logic       update, busy, overrun;

    pong_frame_scheduler_if vga_if ();

    pong_frame_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .p1_x       (dx[0]),
        .p1_y       (dy[0]),
        .p2_x       (dx[1]),
        .p2_y       (dy[1]),
        .ball_x     (dx[2]),
        .ball_y     (dy[2]),
        .vga        (vga_if),
        .update     (update),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    rec_t  obs_q [$];
    rec_t  exp_q [$];
    rec_t  msk_q [$];
    snap_t hist_q [$];

    int    obj_w [3] = '{10, 10, 4};
    int    obj_h [3] = '{48, 48, 4};
    int    mx [3];
    int    my [3];
    bit    m_valid;
    logic [8:0] nxt_x [3];
    logic [7:0] nxt_y [3];
    bit    nxt_en;

    // ---------------- reference model ----------------
    function automatic rec_t mk(bit pl, int xv, int yv, logic [2:0] c, bit up);
        return {pl, 9'(xv), 8'(yv), c, up, 1'b1};
    endfunction

    function automatic void push_obj(int ox, int oy, int o, logic [2:0] c);
        int px;
        int py;
        for (int r = 0; r < obj_h[o]; r++) begin
            for (int cc = 0; cc < obj_w[o]; cc++) begin
                px = ox + cc;
                py = oy + r;
                exp_q.push_back(mk((px < 320) && (py < 240), px, py, c, 1'b0));
                msk_q.push_back(MASK_ALL);
            end
        end
    endfunction

    function automatic void model_prefix();
        exp_q.delete();
        msk_q.delete();
        if (m_valid) begin
            for (int o = 0; o < 3; o++) push_obj(mx[o], my[o], o, 3'b000);
        end
        exp_q.push_back(mk(1'b0, 0, 0, 3'b000, 1'b1));
        msk_q.push_back(MASK_NOXY);
        exp_q.push_back(mk(1'b0, 0, 0, 3'b000, 1'b0));
        msk_q.push_back(MASK_NOXY);
    endfunction

    function automatic void model_draw(snap_t s);
        mx[0] = int'(s.x0); mx[1] = int'(s.x1); mx[2] = int'(s.x2);
        my[0] = int'(s.y0); my[1] = int'(s.y1); my[2] = int'(s.y2);
        for (int o = 0; o < 3; o++) push_obj(mx[o], my[o], o, 3'b111);
        m_valid = 1'b1;
    endfunction

    // Draw uses whatever positions were on the inputs during the sample cycle.
    function automatic void frame_expect();
        int    sidx;
        snap_t s;
        sidx = exp_q.size() - 1;
        if (sidx < hist_q.size()) s = hist_q[sidx];
        else s = {dx[0], dx[1], dx[2], dy[0], dy[1], dy[2]};
        model_draw(s);
    endfunction

    function automatic int first_mismatch();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) return i;
        end
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic run_frame(input bit toggle, input int extra_at, input int budget);
        bit apply;
        bit ended;
        apply = 1'b0;
        ended = 1'b0;
        obs_q.delete();
        hist_q.delete();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int n = 0; n < budget && !ended; n++) begin
            if (toggle) begin
                for (int o = 0; o < 3; o++) begin
                    dx[o] = 9'($urandom_range(0, 511));
                    dy[o] = 8'($urandom_range(0, 255));
                end
            end
            if (n == extra_at) frame_tick = 1'b1;
            @(negedge clk);
            if (!busy) begin
                ended = 1'b1;
            end else begin
                obs_q.push_back({vga_if.plot, vga_if.x, vga_if.y, vga_if.colour, update, busy});
                hist_q.push_back({dx[0], dx[1], dx[2], dy[0], dy[1], dy[2]});
                apply = update && nxt_en;
            end
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (apply) begin
                for (int o = 0; o < 3; o++) begin
                    dx[o] = nxt_x[o];
                    dy[o] = nxt_y[o];
                end
                apply = 1'b0;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn     = 1'b0;
        frame_tick = 1'b0;
        nxt_en     = 1'b0;
        m_valid    = 1'b0;
        dx[0] = 9'd10;  dy[0] = 8'd96;
        dx[1] = 9'd300; dy[1] = 8'd96;
        dx[2] = 9'd158; dy[2] = 8'd118;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, update, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl busy/update/overrun got=%b exp=000", {busy, update, overrun});
        end
        checks++;
        if ({vga_if.plot, vga_if.x, vga_if.y, vga_if.colour} !== 21'd0) begin
            errors++;
            $display("FAIL reset_pixel plot/x/y/colour got=%b/%0d/%0d/%b exp=0/0/0/000",
                     vga_if.plot, vga_if.x, vga_if.y, vga_if.colour);
        end
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_first_frame();
        int fm;
        model_prefix();
        run_frame(1'b0, -1, 2100);
        frame_expect();
        fm = first_mismatch();
        checks++;
        if (obs_q.size() != 978) begin
            errors++;
            $display("FAIL first_len busy_cycles got=%0d exp=978", obs_q.size());
        end
        checks++;
        if (fm >= 0) begin
            errors++;
            $display("FAIL first_stream idx=%0d got=%h exp=%h", fm, obs_q[fm], exp_q[fm]);
        end
        checks++;
        if (obs_q.size() < 1 || obs_q[0][1] !== 1'b1) begin
            errors++;
            $display("FAIL first_update update at T+1 got=%b exp=1", obs_q.size() > 0 ? obs_q[0][1] : 1'bx);
        end
        checks++;
        if (obs_q.size() < 3 || obs_q[2] !== mk(1'b1, 10, 96, 3'b111, 1'b0)) begin
            errors++;
            $display("FAIL first_plot got=%h exp=%h", obs_q.size() > 2 ? obs_q[2] : 23'hx,
                     mk(1'b1, 10, 96, 3'b111, 1'b0));
        end
    endtask

    task automatic test_second_frame();
        int fm;
        for (int o = 0; o < 3; o++) begin
            nxt_x[o] = dx[o];
            nxt_y[o] = dy[o];
        end
        nxt_y[0] = 8'd100;
        nxt_en   = 1'b1;
        model_prefix();
        run_frame(1'b0, -1, 2100);
        nxt_en = 1'b0;
        frame_expect();
        fm = first_mismatch();
        checks++;
        if (obs_q.size() != 1954) begin
            errors++;
            $display("FAIL second_len busy_cycles got=%0d exp=1954", obs_q.size());
        end
        checks++;
        if (fm >= 0) begin
            errors++;
            $display("FAIL second_stream idx=%0d got=%h exp=%h", fm, obs_q[fm], exp_q[fm]);
        end
        checks++;
        if (obs_q.size() < 1 || obs_q[0] !== mk(1'b1, 10, 96, 3'b000, 1'b0)) begin
            errors++;
            $display("FAIL second_erase_first got=%h exp=%h", obs_q.size() > 0 ? obs_q[0] : 23'hx,
                     mk(1'b1, 10, 96, 3'b000, 1'b0));
        end
        checks++;
        if (obs_q.size() < 979 || obs_q[976][1] !== 1'b1 || obs_q[978] !== mk(1'b1, 10, 100, 3'b111, 1'b0)) begin
            errors++;
            $display("FAIL second_redraw update=%b first_draw=%h exp update=1 first_draw=%h",
                     obs_q.size() > 976 ? obs_q[976][1] : 1'bx,
                     obs_q.size() > 978 ? obs_q[978] : 23'hx, mk(1'b1, 10, 100, 3'b111, 1'b0));
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL second_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_offscreen_ball();
        int fm;
        int nplot;
        dx[2] = 9'd318;
        dy[2] = 8'd238;
        model_prefix();
        run_frame(1'b0, -1, 2100);
        frame_expect();
        fm = first_mismatch();
        nplot = 0;
        for (int i = 1938; i < 1954 && i < obs_q.size(); i++) begin
            if (obs_q[i][22] === 1'b1) nplot++;
        end
        checks++;
        if (obs_q.size() != 1954) begin
            errors++;
            $display("FAIL edge_len busy_cycles got=%0d exp=1954", obs_q.size());
        end
        checks++;
        if (fm >= 0) begin
            errors++;
            $display("FAIL edge_stream idx=%0d got=%h exp=%h", fm, obs_q[fm], exp_q[fm]);
        end
        checks++;
        if (nplot != 4) begin
            errors++;
            $display("FAIL edge_ball_plots got=%0d exp=4", nplot);
        end
    endtask

    task automatic test_random_frames();
        int fm;
        int exp_len;
        for (int f = 0; f < 3; f++) begin
            for (int o = 0; o < 3; o++) begin
                dx[o] = 9'($urandom_range(0, 511));
                dy[o] = 8'($urandom_range(0, 255));
            end
            model_prefix();
            run_frame(1'b0, -1, 2100);
            frame_expect();
            fm = first_mismatch();
            exp_len = exp_q.size();
            checks++;
            if (obs_q.size() != exp_len || exp_len != 1954) begin
                errors++;
                $display("FAIL rand%0d_len busy_cycles got=%0d exp=1954", f, obs_q.size());
            end
            checks++;
            if (fm >= 0) begin
                errors++;
                $display("FAIL rand%0d_stream idx=%0d got=%h exp=%h", f, fm, obs_q[fm], exp_q[fm]);
            end
        end
    endtask

    task automatic test_toggle_positions();
        int fm;
        model_prefix();
        run_frame(1'b1, -1, 2100);
        frame_expect();
        fm = first_mismatch();
        checks++;
        if (obs_q.size() != 1954) begin
            errors++;
            $display("FAIL toggle_len busy_cycles got=%0d exp=1954", obs_q.size());
        end
        checks++;
        if (fm >= 0) begin
            errors++;
            $display("FAIL toggle_stream idx=%0d got=%h exp=%h", fm, obs_q[fm], exp_q[fm]);
        end
    endtask

    task automatic test_overrun();
        int fm;
        int busy_seen;
        model_prefix();
        run_frame(1'b0, 1500, 2100);
        frame_expect();
        fm = first_mismatch();
        checks++;
        if (obs_q.size() != 1954 || fm >= 0) begin
            errors++;
            $display("FAIL overrun_stream len=%0d mismatch_idx=%0d exp len=1954 idx=-1", obs_q.size(), fm);
        end
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL overrun_no_extra busy_cycles got=%0d exp=0", busy_seen);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got=%b exp=1", overrun);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_erase();
        int fm;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (600) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || vga_if.colour !== 3'b000) begin
            errors++;
            $display("FAIL mid_erase busy/colour got=%b/%b exp=1/000", busy, vga_if.colour);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({vga_if.plot, busy, update, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset plot/busy/update/overrun got=%b exp=0000",
                     {vga_if.plot, busy, update, overrun});
        end
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        model_prefix();
        run_frame(1'b0, -1, 2100);
        frame_expect();
        fm = first_mismatch();
        checks++;
        if (obs_q.size() != 978) begin
            errors++;
            $display("FAIL post_reset_len busy_cycles got=%0d exp=978", obs_q.size());
        end
        checks++;
        if (fm >= 0) begin
            errors++;
            $display("FAIL post_reset_stream idx=%0d got=%h exp=%h", fm, obs_q[fm], exp_q[fm]);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_offscreen_ball();
        test_random_frames();
        test_toggle_positions();
        test_overrun();
        test_reset_mid_erase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
